// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, redirect/stall/halt controls and IF/ID register outputs.
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_stage_if;
   logic [31:0] inst_addr;
   logic [31:0] inst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic [31:0] pc;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   modport master (
      output inst_addr, pc, if_id_inst, if_id_pc4, if_id_valid, halted,
`ifdef FETCH_PERF_CNT_EN
      output fetch_count, stall_count,
`endif
      input  inst, stall, redirect, redirect_pc, halt_req
   );

   modport slave (
      input  inst_addr, pc, if_id_inst, if_id_pc4, if_id_valid, halted,
`ifdef FETCH_PERF_CNT_EN
      input  fetch_count, stall_count,
`endif
      output inst, stall, redirect, redirect_pc, halt_req
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC, addresses combinational imem, fills IF/ID; one edge to IF/ID, one-bubble redirect.
// Decode stall holds PC and IF/ID; halt freezes fetch until a redirect. FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_DEPTH = 128
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   localparam logic [31:0] WRAP_ADDR = 32'(MEM_DEPTH * 4);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic [31:0] target_pc;

   assign pc_plus4  = pc_q + 32'd4;
   // Wrap only on sequential increment; redirect targets are taken verbatim.
   assign next_pc   = (pc_plus4 == WRAP_ADDR) ? 32'd0 : pc_plus4;
   assign target_pc = bus.redirect_pc & ~32'd3;

   assign bus.pc        = pc_q;
   assign bus.inst_addr = pc_q >> 2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_BOOT;
         pc_q            <= RESET_PC;
         bus.if_id_inst  <= 32'd0;
         bus.if_id_pc4   <= 32'd0;
         bus.if_id_valid <= 1'b0;
         bus.halted      <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (bus.redirect) begin
                  pc_q            <= target_pc;
                  bus.if_id_inst  <= 32'd0;
                  bus.if_id_pc4   <= 32'd0;
                  bus.if_id_valid <= 1'b0;
               end else if (bus.halt_req) begin
                  bus.if_id_inst  <= 32'd0;
                  bus.if_id_pc4   <= 32'd0;
                  bus.if_id_valid <= 1'b0;
                  bus.halted      <= 1'b1;
                  state           <= ST_HALT;
               end else if (!bus.stall) begin
                  bus.if_id_inst  <= bus.inst;
                  bus.if_id_pc4   <= pc_plus4;
                  bus.if_id_valid <= 1'b1;
                  pc_q            <= next_pc;
               end
            end
            ST_HALT: begin
               // IF/ID was flushed on entry, so leaving leaves it empty.
               if (bus.redirect) begin
                  pc_q       <= target_pc;
                  bus.halted <= 1'b0;
                  state      <= ST_RUN;
               end
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.fetch_count <= 32'd0;
         bus.stall_count <= 32'd0;
      end else if (state == ST_RUN && !bus.redirect && !bus.halt_req) begin
         if (bus.stall) begin
            bus.stall_count <= bus.stall_count + 32'd1;
         end else begin
            bus.fetch_count <= bus.fetch_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, redirect, PC wrap, halt and reset-override scenarios.
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   logic [31:0] mem [128];

   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .MEM_DEPTH (128)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.inst = mem[bus.inst_addr[6:0]];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pc"},     bus.pc, 32'h0);
      check({tag, "_addr"},   bus.inst_addr, 32'h0);
      check({tag, "_inst"},   bus.if_id_inst, 32'h0);
      check({tag, "_pc4"},    bus.if_id_pc4, 32'h0);
      check({tag, "_valid"},  32'(bus.if_id_valid), 32'h0);
      check({tag, "_halted"}, 32'(bus.halted), 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check({tag, "_fcnt"},   bus.fetch_count, 32'h0);
      check({tag, "_scnt"},   bus.stall_count, 32'h0);
`endif
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i);
      mem[0] = 32'h0000_0010;
      mem[1] = 32'h0000_0023;

      rst = 1'b1;
      bus.stall = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.halt_req = 1'b0;
      tick();
      tick();
      check_reset_vals("reset");

      // Boot cycle then two sequential fetches.
      rst = 1'b0;
      tick();
      check("boot_valid", 32'(bus.if_id_valid), 32'h0);
      check("boot_pc", bus.pc, 32'h0);
      tick();
      check("e2_inst", bus.if_id_inst, 32'h10);
      check("e2_pc4", bus.if_id_pc4, 32'h4);
      check("e2_pc", bus.pc, 32'h4);
      check("e2_valid", 32'(bus.if_id_valid), 32'h1);
      tick();
      check("e3_inst", bus.if_id_inst, 32'h23);
      check("e3_pc", bus.pc, 32'h8);
      check("e3_pc4", bus.if_id_pc4, 32'h8);

      // Two stall cycles hold everything.
      bus.stall = 1'b1;
      tick();
      tick();
      check("stall_pc", bus.pc, 32'h8);
      check("stall_inst", bus.if_id_inst, 32'h23);
      check("stall_valid", 32'(bus.if_id_valid), 32'h1);
`ifdef FETCH_PERF_CNT_EN
      check("stall_fcnt", bus.fetch_count, 32'd2);
      check("stall_scnt", bus.stall_count, 32'd2);
`endif
      bus.stall = 1'b0;
      tick();
      check("rel_inst", bus.if_id_inst, 32'hA000_0002);
      check("rel_pc", bus.pc, 32'hC);

      // Redirect beats stall; low address bits dropped.
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h17;
      bus.stall = 1'b1;
      tick();
      check("redir_pc", bus.pc, 32'h14);
      check("redir_addr", bus.inst_addr, 32'h5);
      check("redir_valid", 32'(bus.if_id_valid), 32'h0);
      check("redir_inst", bus.if_id_inst, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("redir_scnt", bus.stall_count, 32'd2);
`endif
      bus.redirect = 1'b0;
      bus.stall = 1'b0;
      tick();
      check("post_redir_inst", bus.if_id_inst, 32'hA000_0005);
      check("post_redir_pc4", bus.if_id_pc4, 32'h18);
      check("post_redir_valid", 32'(bus.if_id_valid), 32'h1);

      // Wrap at end of memory.
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h1F8;
      tick();
      bus.redirect = 1'b0;
      check("wrap_setup_pc", bus.pc, 32'h1F8);
      tick();
      check("w126_inst", bus.if_id_inst, 32'hA000_007E);
      check("w126_pc", bus.pc, 32'h1FC);
      check("w127_addr", bus.inst_addr, 32'd127);
      tick();
      check("w127_inst", bus.if_id_inst, 32'hA000_007F);
      check("w127_pc4", bus.if_id_pc4, 32'h200);
      check("wrap_pc", bus.pc, 32'h0);
      check("wrap_addr", bus.inst_addr, 32'h0);
      tick();
      check("after_wrap_inst", bus.if_id_inst, 32'h10);
      check("after_wrap_pc", bus.pc, 32'h4);

      // Halt: frozen regardless of stall/halt_req activity.
      bus.halt_req = 1'b1;
      tick();
      check("halt_halted", 32'(bus.halted), 32'h1);
      check("halt_valid", 32'(bus.if_id_valid), 32'h0);
      check("halt_pc", bus.pc, 32'h4);
      for (int i = 0; i < 5; i++) begin
         bus.stall = i[0];
         bus.halt_req = ~i[0];
         tick();
         check("halt_hold_pc", bus.pc, 32'h4);
         check("halt_hold_halted", 32'(bus.halted), 32'h1);
         check("halt_hold_valid", 32'(bus.if_id_valid), 32'h0);
      end
      bus.stall = 1'b0;
      bus.halt_req = 1'b0;
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h8;
      tick();
      check("unhalt_pc", bus.pc, 32'h8);
      check("unhalt_halted", 32'(bus.halted), 32'h0);
      check("unhalt_valid", 32'(bus.if_id_valid), 32'h0);
      bus.redirect = 1'b0;
      tick();
      check("unhalt_inst", bus.if_id_inst, 32'hA000_0002);
      check("unhalt_fetch_pc", bus.pc, 32'hC);

      // Out-of-range redirect loaded verbatim.
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h400;
      tick();
      bus.redirect = 1'b0;
      check("far_pc", bus.pc, 32'h400);
      check("far_addr", bus.inst_addr, 32'h100);

      // Reset while halted and stalled.
      bus.halt_req = 1'b1;
      tick();
      bus.halt_req = 1'b0;
      check("halt2", 32'(bus.halted), 32'h1);
      bus.stall = 1'b1;
      rst = 1'b1;
      tick();
      check_reset_vals("rst_halt");

      // Boot ignores stall; stall in RUN keeps the bubble.
      rst = 1'b0;
      tick();
      check("boot2_valid", 32'(bus.if_id_valid), 32'h0);
      tick();
      check("stall_bubble_valid", 32'(bus.if_id_valid), 32'h0);
      check("stall_bubble_pc", bus.pc, 32'h0);

      // Reset overrides a concurrent redirect.
      bus.stall = 1'b0;
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h40;
      rst = 1'b1;
      tick();
      check_reset_vals("rst_redir");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
